// File: rtl/freq_meter_multi_if.sv
// Control/readback bundle for freq_meter_multi: measurement request, status and result mux.
interface freq_meter_multi_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned WIN_W  = 32
);
    localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             start;
    logic             continuous;
    logic [WIN_W-1:0] window_len;
    logic [SEL_W-1:0] rd_sel;
    logic [CNT_W-1:0] rd_count;
    logic             rd_overflow;
    logic             busy;
    logic             done;
    logic             valid;

    modport master (
        output start, continuous, window_len, rd_sel,
        input  rd_count, rd_overflow, busy, done, valid
    );

    modport slave (
        input  start, continuous, window_len, rd_sel,
        output rd_count, rd_overflow, busy, done, valid
    );
endinterface

// File: rtl/freq_meter_multi.sv
// Multi-channel frequency meter: counts synchronised toggle edges over a ref_clock gate window
// and double-buffers the per-channel counts for readback.
module freq_meter_multi #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned WIN_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              ref_clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] target_toggle,
    freq_meter_multi_if.slave bus
);
    localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE, S_LATCH} state_t;

    state_t            state_q;
    logic [WIN_W-1:0]  win_cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              valid_q;

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] hist_q;
    logic [NUM_CH-1:0] edge_det;

    logic [CNT_W-1:0]  cnt_q     [NUM_CH];
    logic [NUM_CH-1:0] ovf_q;
    logic [CNT_W-1:0]  res_cnt_q [NUM_CH];
    logic [NUM_CH-1:0] res_ovf_q;

    logic [CNT_W-1:0]  rd_count_c;
    logic              rd_overflow_c;

    // Toggle synchronisers plus one history stage; any transition is one edge.
    always_ff @(posedge ref_clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            hist_q <= '0;
        end else begin
            sync_q[0] <= target_toggle;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_det = sync_q[SYNC_STAGES-1] ^ hist_q;

    // Measurement sequencer; edges outside MEASURE are dropped.
    always_ff @(posedge ref_clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            win_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            ovf_q     <= '0;
            res_ovf_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]     <= '0;
                res_cnt_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_ARM;
                        busy_q  <= 1'b1;
                    end
                end
                S_ARM: begin
                    for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
                    ovf_q     <= '0;
                    win_cnt_q <= (bus.window_len == '0) ? WIN_W'(1) : bus.window_len;
                    state_q   <= S_MEASURE;
                end
                S_MEASURE: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (edge_det[i]) begin
                            if (cnt_q[i] == CNT_MAX) ovf_q[i] <= 1'b1;
                            else                     cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                        end
                    end
                    win_cnt_q <= win_cnt_q - WIN_W'(1);
                    if (win_cnt_q == WIN_W'(1)) state_q <= S_LATCH;
                end
                S_LATCH: begin
                    for (int i = 0; i < NUM_CH; i++) res_cnt_q[i] <= cnt_q[i];
                    res_ovf_q <= ovf_q;
                    done_q    <= 1'b1;
                    valid_q   <= 1'b1;
                    if (bus.continuous) begin
                        state_q <= S_ARM;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Zero-latency result readback; unmapped selects read as zero.
    always_comb begin
        rd_count_c    = '0;
        rd_overflow_c = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.rd_sel == SEL_W'(i)) begin
                rd_count_c    = res_cnt_q[i];
                rd_overflow_c = res_ovf_q[i];
            end
        end
    end

    assign bus.rd_count    = rd_count_c;
    assign bus.rd_overflow = rd_overflow_c;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.valid       = valid_q;
endmodule

// File: tb/tb_freq_meter_multi.sv
// Directed bench for freq_meter_multi (3 channels, 8-bit counters) with an expected-result queue.
module tb_freq_meter_multi;
    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned WIN_W  = 32;

    typedef struct packed {
        logic [NUM_CH-1:0]            ovf;
        logic [NUM_CH-1:0][CNT_W-1:0] cnt;
    } exp_t;

    logic              ref_clock = 1'b0;
    logic              reset     = 1'b0;
    logic [NUM_CH-1:0] toggle_r  = '0;
    int                tog_per [NUM_CH];
    int                n_cmp = 0;
    int                n_err = 0;
    exp_t              sb_q [$];

    freq_meter_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

    freq_meter_multi #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_W(WIN_W), .SYNC_STAGES(2)
    ) dut (
        .ref_clock    (ref_clock),
        .reset        (reset),
        .target_toggle(toggle_r),
        .bus          (bus)
    );

    always #5 ref_clock = ~ref_clock;

    // Per-channel toggle source: flips every tog_per[i] ref cycles, idle when 0.
    initial begin
        int tog_cnt [NUM_CH];
        for (int i = 0; i < NUM_CH; i++) tog_cnt[i] = 0;
        forever begin
            @(posedge ref_clock);
            #2;
            for (int i = 0; i < NUM_CH; i++) begin
                if (tog_per[i] != 0) begin
                    tog_cnt[i]++;
                    if (tog_cnt[i] >= tog_per[i]) begin
                        tog_cnt[i]  = 0;
                        toggle_r[i] = ~toggle_r[i];
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int c0, input int c1, input int c2, input logic [NUM_CH-1:0] o);
        exp_t e;
        e.cnt[0] = CNT_W'(c0);
        e.cnt[1] = CNT_W'(c1);
        e.cnt[2] = CNT_W'(c2);
        e.ovf    = o;
        sb_q.push_back(e);
    endtask

    task automatic set_tog(input int p0, input int p1, input int p2);
        tog_per[0] = p0;
        tog_per[1] = p1;
        tog_per[2] = p2;
        repeat (20) @(posedge ref_clock);
        #1;
    endtask

    task automatic start_run(input int win, input logic cont);
        bus.window_len = WIN_W'(win);
        bus.continuous = cont;
        bus.start      = 1'b1;
        @(posedge ref_clock);
        #1;
        bus.start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge ref_clock);
            #1;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge ref_clock);
            #1;
            if (bus.done === 1'b1) n++;
        end
    endtask

    // Wait for done, check its latency, then pop the expected set and sweep rd_sel.
    task automatic measure_check(input string tag, input int exp_lat);
        int   lat;
        exp_t e;
        wait_done(exp_lat + 50, lat);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_valid"}, 32'(bus.valid), 32'd1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_entry"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            for (int ch = 0; ch < NUM_CH; ch++) begin
                bus.rd_sel = 2'(ch);
                #1;
                check($sformatf("%s_cnt%0d", tag, ch), 32'(bus.rd_count), 32'(e.cnt[ch]));
                check($sformatf("%s_ovf%0d", tag, ch), 32'(bus.rd_overflow), 32'(e.ovf[ch]));
            end
            bus.rd_sel = 2'(NUM_CH);
            #1;
            check({tag, "_oob_cnt"}, 32'(bus.rd_count), 32'd0);
            check({tag, "_oob_ovf"}, 32'(bus.rd_overflow), 32'd0);
            bus.rd_sel = '0;
        end
    endtask

    initial begin
        int n;
        bus.start      = 1'b0;
        bus.continuous = 1'b0;
        bus.window_len = '0;
        bus.rd_sel     = '0;
        for (int i = 0; i < NUM_CH; i++) tog_per[i] = 0;

        // Reset state
        reset = 1'b0;
        repeat (3) @(posedge ref_clock);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_cnt", 32'(bus.rd_count), 32'd0);
        check("rst_ovf", 32'(bus.rd_overflow), 32'd0);
        reset = 1'b1;
        @(posedge ref_clock);
        #1;

        // Single shot, ch0 toggling every 5 cycles
        set_tog(5, 0, 0);
        push_exp(200, 0, 0, 3'b000);
        start_run(1000, 1'b0);
        check("t1_busy", 32'(bus.busy), 32'd1);
        measure_check("t1", 1002);
        check("t1_busy_end", 32'(bus.busy), 32'd0);
        @(posedge ref_clock);
        #1;
        check("t1_done_pulse", 32'(bus.done), 32'd0);

        // Saturation on ch1
        set_tog(0, 2, 0);
        push_exp(0, 255, 0, 3'b010);
        start_run(2000, 1'b0);
        measure_check("t2", 2002);

        // Continuous: three windows, then continuous dropped during the fourth
        set_tog(5, 4, 0);
        repeat (4) push_exp(20, 25, 0, 3'b000);
        start_run(100, 1'b1);
        measure_check("t3w1", 102);
        check("t3w1_busy", 32'(bus.busy), 32'd1);
        measure_check("t3w2", 102);
        check("t3w2_busy", 32'(bus.busy), 32'd1);
        measure_check("t3w3", 102);
        bus.continuous = 1'b0;
        check("t3w3_busy", 32'(bus.busy), 32'd1);
        measure_check("t3w4", 102);
        check("t3w4_busy", 32'(bus.busy), 32'd0);
        count_dones(300, n);
        check("t3_no_more_done", 32'(n), 32'd0);

        // Asynchronous reset mid-window
        start_run(1000, 1'b0);
        repeat (500) @(posedge ref_clock);
        #3;
        reset = 1'b0;
        #1;
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_done", 32'(bus.done), 32'd0);
        check("t5_valid", 32'(bus.valid), 32'd0);
        check("t5_cnt0", 32'(bus.rd_count), 32'd0);
        bus.rd_sel = 2'd1;
        #1;
        check("t5_cnt1", 32'(bus.rd_count), 32'd0);
        bus.rd_sel = '0;
        count_dones(5, n);
        check("t5_no_done", 32'(n), 32'd0);
        reset = 1'b1;
        set_tog(5, 4, 0);
        push_exp(200, 250, 0, 3'b000);
        start_run(1000, 1'b0);
        measure_check("t5_restart", 1002);

        // Zero-length window, start held high across the busy period
        set_tog(0, 0, 0);
        push_exp(0, 0, 0, 3'b000);
        bus.window_len = '0;
        bus.continuous = 1'b0;
        bus.start      = 1'b1;
        @(posedge ref_clock);
        #1;
        measure_check("t4", 3);
        bus.start = 1'b0;
        count_dones(30, n);
        check("t4_no_extra_done", 32'(n), 32'd0);
        check("t4_busy", 32'(bus.busy), 32'd0);

        // Distinct per-channel results for the readback sweep
        set_tog(5, 4, 8);
        push_exp(80, 100, 50, 3'b000);
        start_run(400, 1'b0);
        measure_check("t6", 402);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
